// File: rtl/pulse_symbol_sequencer_pkg.sv
// Shared definitions for the pulse symbol sequencer: default sizes and FSM state encoding.
package pulse_symbol_sequencer_pkg;

  localparam int DEF_TIMER_WIDTH = 8;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_LOOP_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  // Level bit plus duration.
  function automatic int sym_width(input int timer_width);
    return 1 + timer_width;
  endfunction

endpackage

// File: rtl/pulse_symbol_sequencer_if.sv
// Host, control and timer signals of the pulse symbol sequencer, bundled as one interface.
interface pulse_symbol_sequencer_if #(
  parameter int TIMER_WIDTH = 8,
  parameter int DEPTH       = 8,
  parameter int LOOP_WIDTH  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic                   wr_level;
  logic [TIMER_WIDTH-1:0] wr_duration;
  logic [AW:0]            seq_len;
  logic [LOOP_WIDTH-1:0]  loop_count;
  logic                   idle_level;
  logic                   start;
  logic                   stop;
  logic                   tim_done;
  logic                   tim_trig;
  logic [TIMER_WIDTH-1:0] tim_duration;
  logic                   pulse_out;
  logic                   busy;
  logic                   done_pulse;
  logic                   wr_err;

  modport master (
    output wr_en, wr_addr, wr_level, wr_duration, seq_len, loop_count,
           idle_level, start, stop, tim_done,
    input  tim_trig, tim_duration, pulse_out, busy, done_pulse, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_level, wr_duration, seq_len, loop_count,
           idle_level, start, stop, tim_done,
    output tim_trig, tim_duration, pulse_out, busy, done_pulse, wr_err
  );

endinterface

// File: rtl/pulse_symbol_sequencer_store.sv
// Symbol register file: one write port, one combinational read port, no reset.
module pulse_symbol_sequencer_store #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pulse_symbol_sequencer.sv
// Plays a stored list of (level, duration) symbols on pulse_out by driving an external timer,
// repeating the list loop_count times (0 = until stop).
module pulse_symbol_sequencer
  import pulse_symbol_sequencer_pkg::*;
#(
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int LOOP_WIDTH  = DEF_LOOP_WIDTH
) (
  input logic                     clk,
  input logic                     sys_rst,
  pulse_symbol_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = sym_width(TIMER_WIDTH);

  state_t                 r_state;
  logic [AW-1:0]          r_idx;
  logic [LOOP_WIDTH-1:0]  r_loops;
  logic                   r_trig;
  logic [TIMER_WIDTH-1:0] r_dur;
  logic                   r_pulse;
  logic                   r_done;
  logic                   r_wr_err;

  logic [AW:0]            w_eff_len;
  logic                   w_last;
  logic                   w_we;
  logic [SW-1:0]          w_rdata;
  logic                   w_rd_level;
  logic [TIMER_WIDTH-1:0] w_rd_dur;

  assign w_eff_len = (bus.seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.seq_len;
  assign w_last    = ({1'b0, r_idx} == w_eff_len - 1'b1);
  assign w_we      = bus.wr_en && (r_state == ST_IDLE);

  pulse_symbol_sequencer_store #(
    .DEPTH (DEPTH),
    .W     (SW)
  ) u_store (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.wr_addr),
    .i_wdata ({bus.wr_level, bus.wr_duration}),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  assign {w_rd_level, w_rd_dur} = w_rdata;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_loops  <= '0;
      r_trig   <= 1'b0;
      r_dur    <= '0;
      r_pulse  <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= bus.wr_en && (r_state != ST_IDLE);
      if (bus.stop) begin
        r_state <= ST_IDLE;
        r_trig  <= 1'b0;
        r_pulse <= bus.idle_level;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_pulse <= bus.idle_level;
            if (bus.start && (w_eff_len != '0)) begin
              r_idx   <= '0;
              r_loops <= bus.loop_count;
              r_state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (w_rd_dur == '0) begin
              r_state <= ST_ADVANCE;
            end else begin
              r_pulse <= w_rd_level;
              r_dur   <= w_rd_dur;
              r_trig  <= 1'b1;
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            r_trig <= 1'b0;
            if (bus.tim_done) r_state <= ST_ADVANCE;
          end
          ST_ADVANCE: begin
            if (w_last) begin
              // r_loops==0 only when the run started with loop_count==0: play until stop.
              if ((r_loops == '0) || (r_loops > LOOP_WIDTH'(1))) begin
                if (r_loops != '0) r_loops <= r_loops - 1'b1;
                r_idx   <= '0;
                r_state <= ST_LOAD;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_LOAD;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.tim_trig     = r_trig;
  assign bus.tim_duration = r_dur;
  assign bus.pulse_out    = r_pulse;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done_pulse   = r_done;
  assign bus.wr_err       = r_wr_err;

endmodule

// File: tb/tb_pulse_symbol_sequencer.sv
// Directed bench: sequencer paired with a small countdown timer model.
module tb_pulse_symbol_sequencer;
  localparam int TW = 8;
  localparam int D  = 8;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  pulse_symbol_sequencer_if #(.TIMER_WIDTH(TW), .DEPTH(D), .LOOP_WIDTH(LW)) bus ();

  pulse_symbol_sequencer #(.TIMER_WIDTH(TW), .DEPTH(D), .LOOP_WIDTH(LW)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // Timer: loads on trig, counts down, done is high while count==1.
  logic [TW-1:0] t_cnt;
  always @(posedge clk) begin
    if (sys_rst)           t_cnt <= '0;
    else if (bus.tim_trig) t_cnt <= bus.tim_duration;
    else if (t_cnt != 0)   t_cnt <= t_cnt - 1'b1;
  end
  assign bus.tim_done = (t_cnt == 1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_trig = 0, n_done = 0, n_hi = 0, last_trig = 0, gap = 0;
  logic [15:0] pat = '0;
  always @(negedge clk) begin
    if (bus.tim_trig) begin
      n_trig++;
      pat = {pat[14:0], bus.pulse_out};
      gap = cyc - last_trig;
      last_trig = cyc;
    end
    if (bus.done_pulse) n_done++;
    if (bus.pulse_out)  n_hi++;
  end

  int n_vec = 0, n_err = 0;
  int b_trig, b_done, b_hi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_trig = n_trig; b_done = n_done; b_hi = n_hi;
  endtask

  task automatic wr_sym(input int addr, input logic lvl, input int dur);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'(addr); bus.wr_level = lvl; bus.wr_duration = 8'(dur);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic go();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit got = 0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      if (bus.done_pulse) begin
        got = 1;
        chk({tag, " busy@done"}, bus.busy, 0);
      end
    end
    chk({tag, " done"}, got, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    sys_rst = 1'b1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_level = 0; bus.wr_duration = 0;
    bus.seq_len = 0; bus.loop_count = 0; bus.idle_level = 0; bus.start = 0; bus.stop = 0;
    repeat (2) @(negedge clk);
    chk("rst pulse", bus.pulse_out, 0);
    chk("rst busy",  bus.busy, 0);
    chk("rst trig",  bus.tim_trig, 0);
    chk("rst dur",   bus.tim_duration, 0);
    sys_rst = 1'b0;

    // 1: {1,5},{0,3} once
    wr_sym(0, 1, 5); wr_sym(1, 0, 3);
    bus.seq_len = 2; bus.loop_count = 1;
    snap(); go(); wait_done("t1", 100);
    chk("t1 trig", n_trig - b_trig, 2);
    chk("t1 donecnt", n_done - b_done, 1);
    chk("t1 hi", n_hi - b_hi, 8);
    chk("t1 gap", gap, 8);
    chk("t1 pat", pat[1:0], 2'b10);

    // 2: three passes
    bus.loop_count = 3;
    snap(); go(); wait_done("t2", 200);
    chk("t2 trig", n_trig - b_trig, 6);
    chk("t2 donecnt", n_done - b_done, 1);
    chk("t2 pat", pat[5:0], 6'b101010);
    chk("t2 hi", n_hi - b_hi, 24);

    // 3: middle symbol skipped
    wr_sym(0, 1, 4); wr_sym(1, 1, 0); wr_sym(2, 0, 2);
    bus.seq_len = 3; bus.loop_count = 1;
    snap(); go(); wait_done("t3", 100);
    chk("t3 trig", n_trig - b_trig, 2);
    chk("t3 gap", gap, 9);
    chk("t3 pat", pat[1:0], 2'b10);

    // 4: endless loop, stop in WAIT of second symbol
    wr_sym(1, 0, 3);
    bus.seq_len = 2; bus.loop_count = 0; bus.idle_level = 1;
    snap(); go();
    begin
      int seen = 0;
      for (int k = 0; k < 100 && seen < 2; k++) begin
        @(negedge clk);
        if (bus.tim_trig) seen++;
      end
      chk("t4 reached", seen, 2);
    end
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    chk("t4 busy", bus.busy, 0);
    chk("t4 pulse", bus.pulse_out, 1);
    chk("t4 trig", bus.tim_trig, 0);
    repeat (8) @(negedge clk);
    chk("t4 late busy", bus.busy, 0);
    chk("t4 nodone", n_done - b_done, 0);
    chk("t4 trigcnt", n_trig - b_trig, 2);

    // 5: write while busy is dropped
    bus.idle_level = 0;
    go(); repeat (3) @(negedge clk);
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_level = 0; bus.wr_duration = 9;
    @(negedge clk); bus.wr_en = 0;
    chk("t5 wr_err", bus.wr_err, 1);
    @(negedge clk);
    chk("t5 wr_err clr", bus.wr_err, 0);
    bus.stop = 1; @(negedge clk); bus.stop = 0;
    repeat (8) @(negedge clk);
    bus.seq_len = 1; bus.loop_count = 1;
    snap(); go(); wait_done("t5", 100);
    chk("t5 lvl", pat[0], 1);
    chk("t5 hi", n_hi - b_hi, 7);
    bus.seq_len = 0;
    go();
    chk("t5 len0 busy", bus.busy, 0);
    @(negedge clk);
    chk("t5 len0 busy2", bus.busy, 0);

    // clamp: seq_len 15 plays all 8 entries
    for (int i = 0; i < 8; i++) wr_sym(i, 1'(i), 1);
    bus.seq_len = 15;
    snap(); go(); wait_done("clamp", 200);
    chk("clamp trig", n_trig - b_trig, 8);
    chk("clamp pat", pat[7:0], 8'b01010101);

    // 6: start+stop together, then reset mid-run
    bus.seq_len = 2;
    @(negedge clk); bus.start = 1; bus.stop = 1;
    @(negedge clk); bus.start = 0; bus.stop = 0;
    chk("t6 startstop", bus.busy, 0);
    bus.loop_count = 0; bus.idle_level = 1;
    go(); repeat (4) @(negedge clk);
    chk("t6 running", bus.busy, 1);
    sys_rst = 1;
    @(negedge clk);
    chk("t6 rst pulse", bus.pulse_out, 0);
    chk("t6 rst trig", bus.tim_trig, 0);
    chk("t6 rst busy", bus.busy, 0);
    chk("t6 rst done", bus.done_pulse, 0);
    chk("t6 rst wrerr", bus.wr_err, 0);
    chk("t6 rst dur", bus.tim_duration, 0);
    sys_rst = 0;
    @(negedge clk);
    chk("t6 idle lvl", bus.pulse_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
